// File: rtl/base_askid.sv
// base_askid: two-entry valid/ready register slice; clk, reset (async active-low), i_v/i_d/i_r upstream, o_v/o_d/o_r downstream, o_cnt occupancy
module base_askid #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  input  logic [0:width-1] i_d,
  output logic             i_r,
  output logic             o_v,
  output logic [0:width-1] o_d,
  input  logic             o_r,
  output logic [1:0]       o_cnt
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;
  logic [0:width-1] skid;
  logic [1:0] nxt;
  logic in_x, out_x;
  assign in_x  = i_v & i_r;
  assign out_x = o_v & o_r;
  always_comb
    nxt = o_cnt == EMPTY ? (in_x ? ONE : EMPTY) :
          o_cnt == ONE   ? (in_x & ~out_x ? TWO : ~in_x & out_x ? EMPTY : ONE) :
                           (out_x ? ONE : TWO);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_cnt <= EMPTY;
      o_v   <= 1'b0;
      i_r   <= 1'b0;
      o_d   <= '0;
      skid  <= '0;
    end else begin
      o_cnt <= nxt;
      o_v   <= nxt != EMPTY;
      i_r   <= nxt != TWO;
      o_d   <= in_x & (~o_v | out_x) ? i_d : out_x & (o_cnt == TWO) ? skid : o_d;
      skid  <= in_x & o_v & ~out_x ? i_d : skid;
    end
  end
endmodule

// File: doc/base_askid.md
# base_askid

Two-entry valid/ready register slice that registers both the forward path (`o_v`, `o_d`) and the reverse path (`i_r`). No output depends combinationally on any input, so it breaks long handshake paths in either direction. It sits between any producer and consumer using the codebase's valid/ready streaming protocol. Sustained throughput is one beat per cycle.

## Interface
- `width`, default 1: data width in bits.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_v`  in  1  upstream valid.
- `i_d`  in  [0:width-1]  upstream data.
- `i_r`  out  1  upstream ready; driven directly by a flop.
- `o_v`  out  1  downstream valid; driven directly by a flop.
- `o_d`  out  [0:width-1]  downstream data; driven directly by the main data register.
- `o_r`  in  1  downstream ready.
- `o_cnt`  out  2  occupancy, 0..2; driven directly by the state flops.

## Operation
- **Transfers.**
  - Input transfer occurs when `i_v & i_r`.
  - Output transfer occurs when `o_v & o_r`.
  - Beats are never dropped, duplicated or reordered.
- **Storage.** Two registers: `main` drives `o_d`; `skid` is the overflow entry.
- **States** (encoded as `o_cnt`): EMPTY=0, ONE=1, TWO=2.
- **EMPTY**
  - Input transfer: `main` <= `i_d`; go to ONE.
  - Otherwise: stay.
- **ONE**
  - Input and output transfer: `main` <= `i_d`; stay.
  - Input transfer only: `skid` <= `i_d`; go to TWO.
  - Output transfer only: go to EMPTY.
  - Neither: hold.
- **TWO**
  - Output transfer: `main` <= `skid`; go to ONE.
  - Otherwise: hold.
  - `i_r` is 0 in TWO, so no input transfer can occur.
- **Output decode.**
  - `o_v` = (next state != EMPTY), registered.
  - `i_r` = (next state != TWO), registered.
  - Both are therefore consistent with `o_cnt` every cycle.
- **`i_v` while `i_r`=0** has no effect; the upstream holds `i_d`.
- **`o_r` while `o_v`=0** has no effect.
- **`o_d` stability.** `o_d` stays stable while `o_v`=1 and `o_r`=0.
- **Reset** (asynchronous assert, takes effect immediately):
  - State goes to EMPTY.
  - `o_v`=0, `i_r`=0, `o_cnt`=0.
  - `main`=0, `skid`=0.
  - All stored beats are discarded, including mid-stream.
- **After reset deassertion:** `i_r` rises at the first rising edge of `clk`; `o_v` stays 0 until the first accepted beat.

## Timing
- **Latency.** A beat accepted at edge N is visible on `o_v`/`o_d` after edge N, i.e. one cycle later.
- **Throughput.** With `o_r` held 1, one beat per cycle is sustained indefinitely with no bubbles.
- **Backpressure.**
  - `o_r` drops at cycle N while in ONE, with a beat accepted at edge N: the state becomes TWO and `i_r`=0 after edge N.
  - Exactly one extra beat is absorbed beyond the beat presented on `o_d`.
- **Release.**
  - `o_r` rises while in TWO: after the next edge, `o_d` = former `skid` and `i_r`=1.
  - The next input beat can be accepted one edge later.
- **Combinational paths.** None from any input to any output.

## Test plan
- **Reset.** Assert `reset`=0 mid-stream with `o_cnt`=2 -> immediately `o_v`=0, `i_r`=0, `o_cnt`=0. After release, `i_r`=1 one edge later, and no stale beats ever appear.
- **Single beat** (`width`=8). Drive `i_d`=0xA5 with `i_v`=1 for one transfer, `o_r`=1 -> `o_v`=1 and `o_d`=0xA5 exactly one cycle later, then `o_v`=0.
- **Streaming.** Stream 0x00..0x0F back-to-back with `o_r`=1 -> 16 consecutive output cycles carrying 0x00..0x0F in order; `i_r` stays 1 throughout.
- **Backpressure fill.**
  - While streaming, hold `o_r`=0 for 5 cycles -> `o_cnt` reaches 2 and `i_r`=0 within one edge.
  - `o_d` holds its value; upstream holds its beat.
  - On `o_r`=1, all beats arrive in order with none lost.
- **Drain and empty.**
  - Fill to TWO, then set `i_v`=0 and `o_r`=1 -> two output beats, `o_cnt` goes 2->1->0, `o_v`=0 after the second.
  - `i_r`=1 from the first drain edge.
- **Random soak.** Random `i_v`/`o_r` at 50% each for 10,000 cycles with a scoreboard (`width`=8) -> exact in-order match. Also checked every cycle:
  - `o_cnt`<=2.
  - `i_r`==(`o_cnt`!=2).
  - `o_v`==(`o_cnt`!=0).
